charlie7x5_scan: RTL and testbench



---
 rtl/charlie7x5_pkg.sv | 18 +
 rtl/charlie7x5_decode.sv | 22 ++
 rtl/charlie7x5_scan.sv | 119 +++++++++++
 tb/tb_charlie7x5_scan.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/charlie7x5_pkg.sv
// Shared constants and pixel-to-pin mapping for the 7-pin charlieplexed 7x5 matrix.
package charlie7x5_pkg;
  localparam int NUM_PINS = 7;
  localparam int NUM_ROWS = 5;
  localparam logic [2:0] ADDR_CTRL = 3'd7;
  localparam int CTRL_COMMIT = 0;
  localparam int CTRL_ENABLE = 1;

  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_e;

  // Cathode pin for pixel (c,r): (c+1+r) mod 7, never equal to the anode c.
  function automatic logic [2:0] cathode_pin(input logic [2:0] c, input logic [2:0] r);
    logic [3:0] s;
    s = {1'b0, c} + {1'b0, r} + 4'd1;
    if (s >= 4'd7) s = s - 4'd7;
    return s[2:0];
  endfunction
endpackage

// File: rtl/charlie7x5_decode.sv
// Combinational map from one column's 5 pixels to pin enables/levels.
module charlie7x5_decode
  import charlie7x5_pkg::*;
(
  input  logic                active,
  input  logic [2:0]          col,
  input  logic [NUM_ROWS-1:0] pix,
  output logic [NUM_PINS-1:0] oe,
  output logic [NUM_PINS-1:0] o
);
  always_comb begin
    oe = '0;
    o  = '0;
    if (active) begin
      // Lit pixels pull their cathode low; o stays 0 for those pins.
      for (int r = 0; r < NUM_ROWS; r++)
        if (pix[r]) oe[cathode_pin(col, 3'(r))] = 1'b1;
      oe[col] = 1'b1;
      o[col]  = 1'b1;
    end
  end
endmodule

// File: rtl/charlie7x5_scan.sv
// Charlieplex 7x5 scan controller: double-buffered framebuffer, column scan, Wishbone slave.
module charlie7x5_scan
  import charlie7x5_pkg::*;
#(
  parameter int TICKS_PER_COLUMN = 4800,
  parameter int BLANK_TICKS      = 48
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [2:0]          wb_adr,
  input  logic [7:0]          wb_dat_i,
  output logic [7:0]          wb_dat_o,
  output logic                wb_ack,
  output logic [NUM_PINS-1:0] charlie7x5_oe,
  output logic [NUM_PINS-1:0] charlie7x5_o,
  output logic                frame_start
);
  localparam int TW = $clog2(TICKS_PER_COLUMN);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_COLUMN - 1);
  localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_TICKS);

  scan_state_e state, state_nx;
  logic [TW-1:0] tick, tick_nx;
  logic [2:0] col, col_nx;
  logic col_wrap, wrap;

  logic [NUM_PINS-1:0][NUM_ROWS-1:0] front, back;
  logic enable, commit_pending;
  logic req_we;
  logic [2:0] req_adr;
  logic [7:0] req_dat, rdata;
  logic [NUM_PINS-1:0] dec_oe, dec_o;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_BLANK;
      tick  <= '0;
      col   <= '0;
    end else begin
      state <= state_nx;
      tick  <= tick_nx;
      col   <= col_nx;
    end
  end

  always_comb begin
    col_wrap = (tick == TICK_LAST);
    wrap     = col_wrap && (col == 3'd6);
    tick_nx  = col_wrap ? '0 : tick + 1'b1;
    col_nx   = col;
    if (wrap) col_nx = 3'd0;
    else if (col_wrap) col_nx = col + 3'd1;
    state_nx = (tick_nx < TICK_BLANK) ? ST_BLANK : ST_DRIVE;
  end

  always_comb begin
    rdata = '0;
    if (wb_adr == ADDR_CTRL) begin
      rdata[CTRL_COMMIT] = commit_pending;
      rdata[CTRL_ENABLE] = enable;
    end else begin
      rdata[NUM_ROWS-1:0] = back[wb_adr];
    end
  end

  charlie7x5_decode u_decode (
    .active (state == ST_DRIVE && enable),
    .col    (col),
    .pix    (front[col]),
    .oe     (dec_oe),
    .o      (dec_o)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      front          <= '0;
      back           <= '0;
      enable         <= 1'b0;
      commit_pending <= 1'b0;
      wb_ack         <= 1'b0;
      wb_dat_o       <= '0;
      req_we         <= 1'b0;
      req_adr        <= '0;
      req_dat        <= '0;
      frame_start    <= 1'b0;
      charlie7x5_oe  <= '0;
      charlie7x5_o   <= '0;
    end else begin
      frame_start <= wrap;
      if (wrap && commit_pending) begin
        front          <= back;
        commit_pending <= 1'b0;
      end
      if (wb_stb && !wb_ack) begin
        wb_ack   <= 1'b1;
        wb_dat_o <= rdata;
        req_we   <= wb_we;
        req_adr  <= wb_adr;
        req_dat  <= wb_dat_i;
      end else begin
        wb_ack   <= 1'b0;
        wb_dat_o <= '0;
      end
      // Writes land after the swap assignments so a coinciding commit re-arms.
      if (wb_ack && req_we) begin
        if (req_adr == ADDR_CTRL) begin
          if (req_dat[CTRL_COMMIT]) commit_pending <= 1'b1;
          enable <= req_dat[CTRL_ENABLE];
        end else begin
          back[req_adr] <= req_dat[NUM_ROWS-1:0];
        end
      end
      charlie7x5_oe <= dec_oe;
      charlie7x5_o  <= dec_o;
    end
  end
endmodule

// File: tb/tb_charlie7x5_scan.sv
// Bench for charlie7x5_scan: constant-vector table, corner sequences, random traffic vs a cycle model.
module tb_charlie7x5_scan;
  localparam int T = 20;
  localparam int B = 4;
  localparam int FRAME = 7 * T;

  logic clock = 1'b0, reset_n = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [2:0] wb_adr = '0;
  logic [7:0] wb_dat_i = '0;
  logic [7:0] wb_dat_o;
  logic wb_ack, frame_start;
  logic [6:0] oe, o;
  int errors = 0, checks = 0;

  always #5 clock = ~clock;

  charlie7x5_scan #(.TICKS_PER_COLUMN(T), .BLANK_TICKS(B)) dut (
    .clock(clock), .reset_n(reset_n), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
    .charlie7x5_oe(oe), .charlie7x5_o(o), .frame_start(frame_start)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scan position from the cycle count since reset,
  // register file and buffers updated from the observed bus traffic.
  int unsigned m_n = 0;
  logic [4:0] m_front[7], m_back[7];
  logic m_en = 0, m_cp = 0, m_ack = 0, m_rwe = 0;
  logic [2:0] m_radr = 0;
  logic [7:0] m_rdat = 0, m_rd = 0;
  logic [6:0] x_oe = 0, x_o = 0;
  logic x_fs = 0, x_ack = 0;
  logic [7:0] x_dat = 0;
  int tk, cl;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_n = 0; m_en = 0; m_cp = 0; m_ack = 0; m_rwe = 0;
      for (int i = 0; i < 7; i++) begin m_front[i] = 0; m_back[i] = 0; end
      x_oe = 0; x_o = 0; x_fs = 0; x_ack = 0; x_dat = 0;
    end else begin
      tk = int'(m_n % T);
      cl = int'((m_n / T) % 7);
      x_oe = 0; x_o = 0;
      if (tk >= B && m_en) begin
        x_oe[cl] = 1'b1; x_o[cl] = 1'b1;
        for (int r = 0; r < 5; r++)
          if (m_front[cl][r]) x_oe[(cl + 1 + r) % 7] = 1'b1;
      end
      m_rd = (wb_adr == 3'd7) ? {6'd0, m_en, m_cp} : {3'd0, m_back[wb_adr]};
      x_fs = (tk == T - 1 && cl == 6);
      if (x_fs && m_cp) begin
        for (int i = 0; i < 7; i++) m_front[i] = m_back[i];
        m_cp = 0;
      end
      if (m_ack && m_rwe) begin
        if (m_radr == 3'd7) begin
          if (m_rdat[0]) m_cp = 1;
          m_en = m_rdat[1];
        end else m_back[m_radr] = m_rdat[4:0];
      end
      if (wb_stb && !m_ack) begin
        m_ack = 1; x_dat = m_rd; m_rwe = wb_we; m_radr = wb_adr; m_rdat = wb_dat_i;
      end else begin
        m_ack = 0; x_dat = 0;
      end
      x_ack = m_ack;
      m_n++;
    end
  end

  bit sb_on = 0;
  always @(negedge clock) if (sb_on) begin
    check("scoreboard{ack,dat,fs,oe,o}", {wb_ack, wb_dat_o, frame_start, oe, o},
          {x_ack, x_dat, x_fs, x_oe, x_o});
    check("one_anode", ($countones(o) <= 1), 1);
  end

  task automatic wb_write(input logic [2:0] a, input logic [7:0] d);
    wb_stb = 1; wb_we = 1; wb_adr = a; wb_dat_i = d;
    @(negedge clock); check("wr_ack", wb_ack, 1);
    wb_stb = 0; wb_we = 0;
    @(negedge clock);
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [7:0] d);
    wb_stb = 1; wb_we = 0; wb_adr = a;
    @(negedge clock); d = wb_dat_o; check("rd_ack", wb_ack, 1);
    wb_stb = 0;
    @(negedge clock);
  endtask

  task automatic wait_frame();
    int k = 0;
    do begin @(negedge clock); k++; end while (!frame_start && k < 2 * FRAME);
    if (!frame_start) check("frame_timeout", frame_start, 1);
  endtask

  // Wait until the current scan position is (t, c); outputs then show t-1.
  task automatic wait_tc(input int t, input int c);
    int k = 0;
    do begin @(negedge clock); k++; end
    while (!((m_n % T) == t && ((m_n / T) % 7) == c) && k < 2 * FRAME);
    if (k >= 2 * FRAME) check("position_timeout", k, 0);
  endtask

  typedef struct { logic [2:0] c; logic [4:0] d; logic [6:0] oe; logic [6:0] o; } vec_t;
  vec_t tbl[6];
  logic [7:0] rd;
  int acks;

  initial begin
    tbl[0] = '{3'd0, 5'b00001, 7'b0000011, 7'b0000001};
    tbl[1] = '{3'd6, 5'b11111, 7'b1011111, 7'b1000000};
    tbl[2] = '{3'd2, 5'b00000, 7'b0000100, 7'b0000100};
    tbl[3] = '{3'd3, 5'b10101, 7'b1011010, 7'b0001000};
    tbl[4] = '{3'd5, 5'b01010, 7'b0100101, 7'b0100000};
    tbl[5] = '{3'd1, 5'b10000, 7'b1000010, 7'b0000010};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {wb_ack, wb_dat_o, frame_start, oe, o}, 0);
    reset_n = 1; sb_on = 1;

    // Enable with empty framebuffer: anode only, dark in BLANK.
    wb_write(3'd7, 8'h02);
    wait_tc(B + 2, 2);
    check("empty_c2_oe", oe, 7'b0000100); check("empty_c2_o", o, 7'b0000100);
    wait_tc(2, 3);
    check("blank_oe", oe, 0); check("blank_o", o, 0);

    // Back-buffer write without commit must not show.
    wb_write(3'd6, 8'h1F);
    repeat (3) begin
      wait_frame(); wait_tc(B + 2, 6);
      check("nocommit_c6", {oe, o}, {7'b1000000, 7'b1000000});
    end

    for (int i = 0; i < 6; i++) begin
      wb_write(tbl[i].c, {3'b111, tbl[i].d});
      wb_write(3'd7, 8'h03);
      wait_frame(); wait_tc(B + 2, tbl[i].c);
      check("tbl_oe", oe, tbl[i].oe); check("tbl_o", o, tbl[i].o);
      wb_read(3'd7, rd); check("tbl_ctrl", rd, 8'h02);
    end

    // Commit landing on the swap edge: old contents stay, commit re-armed.
    wb_write(3'd4, 8'h01); wb_write(3'd7, 8'h03);
    wait_frame(); wait_tc(B + 2, 4);
    check("pre_swap_c4", {oe, o}, {7'b0110000, 7'b0010000});
    wb_write(3'd4, 8'h02);
    wait_tc(T - 2, 6);
    wb_stb = 1; wb_we = 1; wb_adr = 3'd7; wb_dat_i = 8'h03;
    @(negedge clock); wb_stb = 0; wb_we = 0;
    @(negedge clock); check("swapcyc_fs", frame_start, 1);
    wait_tc(B + 2, 4);
    check("swapcyc_old_c4", {oe, o}, {7'b0110000, 7'b0010000});
    wb_read(3'd7, rd); check("swapcyc_cp", rd, 8'h03);
    wait_frame(); wait_tc(B + 2, 4);
    check("swapcyc_new_c4", {oe, o}, {7'b1010000, 7'b0010000});

    // Strobe held for 6 cycles: acks on alternate cycles only.
    acks = 0;
    wb_stb = 1; wb_we = 0; wb_adr = 3'd7;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (wb_ack) acks++; else check("idle_dat", wb_dat_o, 0);
    end
    wb_stb = 0;
    check("acks_in_6", acks, 3);
    @(negedge clock);

    // Reset pulse during DRIVE clears everything.
    wait_tc(B + 2, 4);
    reset_n = 0;
    @(negedge clock);
    check("rst_pulse_out", {oe, o, frame_start, wb_ack}, 0);
    reset_n = 1;
    wb_write(3'd7, 8'h02);
    wait_tc(B + 2, 4);
    check("post_rst_c4", {oe, o}, {7'b0010000, 7'b0010000});

    // Random bus traffic against the model.
    repeat (3000) begin
      wb_stb = ($urandom_range(0, 2) == 0);
      wb_we = $urandom_range(0, 1);
      wb_adr = 3'($urandom_range(0, 7));
      wb_dat_i = 8'($urandom);
      reset_n = ($urandom_range(0, 999) != 0);
      @(negedge clock);
    end
    wb_stb = 0; reset_n = 1;
    repeat (4) @(negedge clock);
    sb_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
